// File: rtl/pulse_arb_pkg.sv
// Shared FSM state type, counter width and default timing for the pulse arbiter.
package pulse_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STRETCH = 2'd1,
    GAP     = 2'd2
  } arb_state_t;

  localparam int CNT_W               = 8;
  localparam int DEFAULT_STRETCH_LEN = 15;
  localparam int DEFAULT_GAP_LEN     = 15;

  // Counters run down to zero, so a phase of len cycles starts from len-1.
  function automatic logic [CNT_W-1:0] len_to_load(input int len);
    return CNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after last+1 (wrapping).
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   grant,
  output logic               valid
);

  logic [IDX_W-1:0] idx;

  // Walk from the farthest candidate back to the nearest so the nearest one wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      idx = IDX_W'((int'(last) + i) % NUM_SRC);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_arbiter.sv
// Captures single-cycle event strobes and replays them one at a time as stretched pulses
// for a slower domain. Define PULSE_ARB_OVERRUN_EN to add sticky per-source overrun flags.
module pulse_arbiter
  import pulse_arb_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int STRETCH_LEN = DEFAULT_STRETCH_LEN,
  parameter int GAP_LEN     = DEFAULT_GAP_LEN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         pulse_i,
  output logic                       wpulse_o,
  output logic [$clog2(NUM_SRC)-1:0] chan_o,
  output logic [NUM_SRC-1:0]         pending_o,
  output logic                       busy_o
`ifdef PULSE_ARB_OVERRUN_EN
  ,
  output logic [NUM_SRC-1:0]         overrun_o
`endif
);

  localparam int IDX_W = $clog2(NUM_SRC);

  arb_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   chan_q;
  logic               wpulse_q;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               grant_en;
  logic [NUM_SRC-1:0] grant_mask;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (pending_q),
    .last  (last_q),
    .grant (pick_idx),
    .valid (pick_valid)
  );

  // Grants happen only from IDLE or at the last GAP cycle, so chained events stay one
  // full stretch-plus-gap period apart.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    grant_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) grant_en = 1'b1;
      end
      STRETCH: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = len_to_load(GAP_LEN);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (pick_valid) grant_en = 1'b1;
          else            state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    grant_mask = '0;
    if (grant_en) begin
      state_d              = STRETCH;
      cnt_d                = len_to_load(STRETCH_LEN);
      last_d               = pick_idx;
      grant_mask[pick_idx] = 1'b1;
    end

    // A strobe on the granting edge re-arms the bit, so that event is served later.
    pending_d = (pending_q & ~grant_mask) | pulse_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= '0;
      last_q    <= IDX_W'(NUM_SRC - 1);
      wpulse_q  <= 1'b0;
      chan_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      wpulse_q  <= (state_d == STRETCH);
      chan_q    <= (state_d == STRETCH) ? last_d : '0;
    end
  end

`ifdef PULSE_ARB_OVERRUN_EN
  logic [NUM_SRC-1:0] overrun_q;

  // A repeat strobe on an already-pending source (other than on its grant edge) is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) overrun_q <= '0;
    else        overrun_q <= overrun_q | (pulse_i & pending_q & ~grant_mask);
  end

  assign overrun_o = overrun_q;
`endif

  assign wpulse_o  = wpulse_q;
  assign chan_o    = chan_q;
  assign pending_o = pending_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_arbiter.sv
// Self-checking bench for pulse_arbiter: vector table, directed scenarios and random
// stimulus against a window-scheduling reference model.
module tb_pulse_arbiter;

  localparam int NUM_SRC     = 4;
  localparam int STRETCH_LEN = 15;
  localparam int GAP_LEN     = 15;
  localparam int PERIOD      = STRETCH_LEN + GAP_LEN;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   pulse_i = '0;
  logic         wpulse_o;
  logic [1:0]   chan_o;
  logic [3:0]   pending_o;
  logic         busy_o;
`ifdef PULSE_ARB_OVERRUN_EN
  logic [3:0]   overrun_o;
`endif

  always #5 clk = ~clk;

  pulse_arbiter #(
    .NUM_SRC     (NUM_SRC),
    .STRETCH_LEN (STRETCH_LEN),
    .GAP_LEN     (GAP_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pulse_i   (pulse_i),
    .wpulse_o  (wpulse_o),
    .chan_o    (chan_o),
    .pending_o (pending_o),
    .busy_o    (busy_o)
`ifdef PULSE_ARB_OVERRUN_EN
    ,
    .overrun_o (overrun_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: each grant books a window of PERIOD edges; the next grant may
  // happen once that window has elapsed and something is pending.
  int         edge_n  = 0;
  logic [3:0] m_pend  = '0;
  logic [3:0] m_ovr   = '0;
  int         m_last  = NUM_SRC - 1;
  bit         m_have  = 1'b0;
  int         m_gedge = 0;
  int         m_gsrc  = 0;
  int         m_free  = 0;

  int rise_k[$];
  int rise_c[$];

  typedef struct {
    logic       rst_n;
    logic [3:0] pulse;
    logic       wpulse;
    logic [1:0] chan;
    logic       busy;
    logic [3:0] pending;
  } vec_t;

  vec_t vecs[6];

  task automatic checkVal(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d (edge %0d)", name, got, exp, edge_n);
    end
  endtask

  task automatic modelStep(input logic r, input logic [3:0] p);
    logic [3:0] gmask;
    int         k;
    bit         found;
    edge_n++;
    if (!r) begin
      m_pend = '0;
      m_ovr  = '0;
      m_have = 1'b0;
      m_last = NUM_SRC - 1;
      m_free = 0;
    end else begin
      gmask = '0;
      if (edge_n >= m_free && m_pend != '0) begin
        found = 1'b0;
        k     = 0;
        for (int i = 1; i <= NUM_SRC; i++) begin
          if (!found && m_pend[(m_last + i) % NUM_SRC]) begin
            found = 1'b1;
            k     = (m_last + i) % NUM_SRC;
          end
        end
        m_have   = 1'b1;
        m_gedge  = edge_n;
        m_gsrc   = k;
        m_last   = k;
        m_free   = edge_n + PERIOD;
        gmask[k] = 1'b1;
      end
      m_ovr  = m_ovr | (p & m_pend & ~gmask);
      m_pend = (m_pend & ~gmask) | p;
    end
  endtask

  task automatic checkOutput();
    int exp_w;
    int exp_c;
    int exp_b;
    exp_w = (m_have && edge_n >= m_gedge && edge_n <= m_gedge + STRETCH_LEN - 1) ? 1 : 0;
    exp_c = exp_w ? m_gsrc : 0;
    exp_b = (m_have && edge_n <= m_gedge + PERIOD - 1) ? 1 : 0;
    checkVal("model_wpulse", int'(wpulse_o), exp_w);
    checkVal("model_chan", int'(chan_o), exp_c);
    checkVal("model_busy", int'(busy_o), exp_b);
    checkVal("model_pending", int'(pending_o), int'(m_pend));
`ifdef PULSE_ARB_OVERRUN_EN
    checkVal("model_overrun", int'(overrun_o), int'(m_ovr));
`endif
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] p);
    rst_n   = r;
    pulse_i = p;
    @(posedge clk);
    modelStep(r, p);
    #1;
    checkOutput();
  endtask

  // Runs idle steps with up to two injected strobes, logging each wpulse rise.
  task automatic recordRun(input int steps, input int at1, input logic [3:0] v1,
                           input int at2, input logic [3:0] v2);
    logic       prev_w;
    logic [3:0] p;
    rise_k.delete();
    rise_c.delete();
    prev_w = wpulse_o;
    for (int k = 1; k <= steps; k++) begin
      p = '0;
      if (k == at1) p = p | v1;
      if (k == at2) p = p | v2;
      applyStimulus(1'b1, p);
      if (wpulse_o && !prev_w) begin
        rise_k.push_back(k);
        rise_c.push_back(int'(chan_o));
      end
      prev_w = wpulse_o;
    end
  endtask

  task automatic checkRises(input string tag, input int exp_k[4], input int exp_c[4]);
    checkVal({tag, "_rise_count"}, rise_k.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rise_k.size()) begin
        checkVal($sformatf("%s_rise%0d_edge", tag, i), rise_k[i], exp_k[i]);
        checkVal($sformatf("%s_rise%0d_chan", tag, i), rise_c[i], exp_c[i]);
      end
    end
  endtask

  initial begin
    int   b_k[4];
    int   b_c[4];
    int   c_k[4];
    int   c_c[4];
    int   src3_serves;
    int   late_highs;
    logic [3:0] p;
    logic r;

    vecs[0] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000};
    vecs[1] = '{1'b1, 4'b0100, 1'b0, 2'd0, 1'b0, 4'b0100};
    vecs[2] = '{1'b1, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b0000};
    vecs[3] = '{1'b1, 4'b0010, 1'b1, 2'd2, 1'b1, 4'b0010};
    vecs[4] = '{1'b1, 4'b0010, 1'b1, 2'd2, 1'b1, 4'b0010};
    vecs[5] = '{1'b1, 4'b1001, 1'b1, 2'd2, 1'b1, 4'b1011};

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].pulse);
      checkVal($sformatf("tbl%0d_wpulse", i), int'(wpulse_o), int'(vecs[i].wpulse));
      checkVal($sformatf("tbl%0d_chan", i), int'(chan_o), int'(vecs[i].chan));
      checkVal($sformatf("tbl%0d_busy", i), int'(busy_o), int'(vecs[i].busy));
      checkVal($sformatf("tbl%0d_pending", i), int'(pending_o), int'(vecs[i].pending));
    end

    // Single event from idle: rise two edges after the strobe, fixed stretch and gap.
    applyStimulus(1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b1, 4'b0100);
    checkVal("A_k0_wpulse", int'(wpulse_o), 0);
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1'b1, 4'b0000);
      if (k == 1)  begin
        checkVal("A_k1_wpulse", int'(wpulse_o), 1);
        checkVal("A_k1_chan", int'(chan_o), 2);
      end
      if (k == 15) checkVal("A_k15_wpulse", int'(wpulse_o), 1);
      if (k == 16) begin
        checkVal("A_k16_wpulse", int'(wpulse_o), 0);
        checkVal("A_k16_chan", int'(chan_o), 0);
      end
      if (k == 30) checkVal("A_k30_busy", int'(busy_o), 1);
      if (k == 31) checkVal("A_k31_busy", int'(busy_o), 0);
    end

    // All four at once: served 0..3 back to back with no idle in between.
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b1, 4'b1111);
    recordRun(130, 0, 4'b0000, 0, 4'b0000);
    b_k = '{1, 31, 61, 91};
    b_c = '{0, 1, 2, 3};
    checkRises("B", b_k, b_c);
    checkVal("B_idle_after", int'(busy_o), 0);

    // Source 1 strobed on its own grant edge: served again after source 2.
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b1, 4'b0111);
    recordRun(130, 31, 4'b0010, 0, 4'b0000);
    c_k = '{1, 31, 61, 91};
    c_c = '{0, 1, 2, 1};
    checkRises("C", c_k, c_c);

    // Source 3 strobed twice while source 0 is served: coalesced into one service.
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b1, 4'b0001);
    recordRun(100, 3, 4'b1000, 5, 4'b1000);
    src3_serves = 0;
    foreach (rise_c[i]) if (rise_c[i] == 3) src3_serves++;
    checkVal("D_src3_serves", src3_serves, 1);
    checkVal("D_rise_count", rise_k.size(), 2);
`ifdef PULSE_ARB_OVERRUN_EN
    checkVal("D_overrun", int'(overrun_o), 8);
`endif

    // Reset during the fifth stretch cycle with three events pending.
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b1, 4'b0001);
    applyStimulus(1'b1, 4'b1110);
    for (int k = 2; k <= 5; k++) applyStimulus(1'b1, 4'b0000);
    checkVal("E_pre_wpulse", int'(wpulse_o), 1);
    checkVal("E_pre_pending", int'(pending_o), 14);
    applyStimulus(1'b0, 4'b0000);
    checkVal("E_rst_wpulse", int'(wpulse_o), 0);
    checkVal("E_rst_pending", int'(pending_o), 0);
    checkVal("E_rst_busy", int'(busy_o), 0);
    late_highs = 0;
    for (int k = 0; k < 60; k++) begin
      applyStimulus(1'b1, 4'b0000);
      if (wpulse_o) late_highs++;
    end
    checkVal("E_late_highs", late_highs, 0);

    // Random traffic with occasional resets, checked every edge against the model.
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 499) != 0);
      p = '0;
      for (int b = 0; b < NUM_SRC; b++) p[b] = ($urandom_range(0, 39) == 0);
      applyStimulus(r, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
